// File: rtl/ps_pkg.sv
// Shared definitions for the program sequencer of the 4-bit microprocessor.
//   OP_JMP / OP_JNZ : high nibbles of the two branch opcodes
//   NOP_OP          : ALU NOP byte used to fill ir at reset and on a flush
//   br_kind_e       : branch class decoded from an instruction byte
//   jmp_target()    : branch target {ir[3:0], 4'h0}
package ps_pkg;

    localparam logic [3:0] OP_JMP = 4'hE;
    localparam logic [3:0] OP_JNZ = 4'hF;
    localparam logic [7:0] NOP_OP = 8'hC8;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_JMP  = 2'd1,
        BR_JNZ  = 2'd2
    } br_kind_e;

    function automatic br_kind_e decode_branch(input logic [7:0] instr);
        br_kind_e kind;
        kind = BR_NONE;
        if (instr[7:4] == OP_JMP) begin
            kind = BR_JMP;
        end else if (instr[7:4] == OP_JNZ) begin
            kind = BR_JNZ;
        end
        return kind;
    endfunction

    function automatic logic [7:0] jmp_target(input logic [7:0] instr);
        return {instr[3:0], 4'h0};
    endfunction

endpackage

// File: rtl/program_sequencer_reset_sync.sv
// Reset synchroniser for the program sequencer.
// Asserts sync_reset asynchronously when reset_n falls and releases it
// synchronously SYNC_STAGES clock edges after reset_n rises.
// Ports:
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   sync_reset out  active-high reset for downstream stages
module reset_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    output logic sync_reset
);

    logic [SYNC_STAGES-1:0] chain_q;
    logic [SYNC_STAGES-1:0] chain_d;

    // Zeros shift in from bit 0; the output is the last stage.
    always_comb begin
        chain_d = {chain_q[SYNC_STAGES-2:0], 1'b0};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain_q <= '1;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign sync_reset = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/program_sequencer.sv
// Fetch/sequencing front end of the 4-bit microprocessor (fetch + execute).
// Drives pm_addr from pc, registers each fetched byte into ir, resolves
// JMP/JNZ in the execute stage and generates sync_reset.
// Ports:
//   clk        in   system clock (posedge)
//   reset_n    in   asynchronous active-low reset
//   r_eq_0     in   zero flag from the computational unit
//   pm_data    in   program memory read data (combinational from pm_addr)
//   pm_addr    out  program memory address (= pc)
//   ir         out  execute-stage instruction register
//   pc         out  fetch-stage program counter
//   sync_reset out  active-high reset for downstream stages
//   branch_tkn out  1 for the cycle after a taken branch
// Configuration macro: SEQ_BRANCH_FLUSH_EN
//   defined   : taken branch loads NOP_OP into ir (fall-through squashed)
//   undefined : architectural delay slot, fall-through byte executes
module program_sequencer
    import ps_pkg::*;
#(
    parameter int unsigned PC_W         = 8,
    parameter logic [7:0]  RESET_VECTOR = 8'h00,
    parameter logic [7:0]  NOP_OP       = ps_pkg::NOP_OP,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            r_eq_0,
    input  logic [7:0]      pm_data,
    output logic [PC_W-1:0] pm_addr,
    output logic [7:0]      ir,
    output logic [PC_W-1:0] pc,
    output logic            sync_reset,
    output logic            branch_tkn
);

    logic [PC_W-1:0] pc_q, pc_d;
    logic [7:0]      ir_q, ir_d;
    logic            branch_tkn_q, branch_tkn_d;
    br_kind_e        br_kind;
    logic            taken;

    reset_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_reset_sync (
        .clk       (clk),
        .reset_n   (reset_n),
        .sync_reset(sync_reset)
    );

    // Branch resolution in the execute stage; JNZ uses the live r_eq_0.
    always_comb begin
        br_kind = decode_branch(ir_q);
        taken   = 1'b0;
        case (br_kind)
            BR_JMP:  taken = 1'b1;
            BR_JNZ:  taken = !r_eq_0;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        pc_d         = pc_q + PC_W'(1);
        ir_d         = pm_data;
        branch_tkn_d = 1'b0;
        if (sync_reset) begin
            pc_d = PC_W'(RESET_VECTOR);
            ir_d = NOP_OP;
        end else if (taken) begin
            pc_d         = PC_W'(jmp_target(ir_q));
            branch_tkn_d = 1'b1;
`ifdef SEQ_BRANCH_FLUSH_EN
            ir_d         = NOP_OP;
`else
            ir_d         = pm_data;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q         <= PC_W'(RESET_VECTOR);
            ir_q         <= NOP_OP;
            branch_tkn_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            branch_tkn_q <= branch_tkn_d;
        end
    end

    assign pc         = pc_q;
    assign pm_addr    = pc_q;
    assign ir         = ir_q;
    assign branch_tkn = branch_tkn_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer: directed vector table,
// hand-written multi-cycle sequences and a randomized run against an
// instruction-level reference model.
module tb_program_sequencer;

    logic       clk;
    logic       reset_n;
    logic       r_eq_0;
    logic [7:0] pm_data;
    logic [7:0] pm_addr;
    logic [7:0] ir;
    logic [7:0] pc;
    logic       sync_reset;
    logic       branch_tkn;

    logic [7:0] rom [0:255];

    int checks = 0;
    int errors = 0;

`ifdef SEQ_BRANCH_FLUSH_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif

    // Reference model state
    int m_pc;
    int m_ir;
    int m_bt;
    int m_sr_left;

    program_sequencer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .r_eq_0    (r_eq_0),
        .pm_data   (pm_data),
        .pm_addr   (pm_addr),
        .ir        (ir),
        .pc        (pc),
        .sync_reset(sync_reset),
        .branch_tkn(branch_tkn)
    );

    assign pm_data = rom[pm_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model();
        check("pc", int'(pc), m_pc);
        check("pm_addr", int'(pm_addr), m_pc);
        check("ir", int'(ir), m_ir);
        check("branch_tkn", int'(branch_tkn), m_bt);
        check("sync_reset", int'(sync_reset), (m_sr_left > 0) ? 1 : 0);
    endtask

    // One clock: model advances from the instruction-level rules, then outputs are compared.
    task automatic step();
        int fetched;
        bit take;
        @(posedge clk);
        fetched = int'(rom[m_pc]);
        if (!reset_n) begin
            m_pc = 0; m_ir = 'hC8; m_bt = 0;
        end else if (m_sr_left > 0) begin
            m_pc = 0; m_ir = 'hC8; m_bt = 0;
            m_sr_left--;
        end else begin
            take = (m_ir >= 'hE0) && !((m_ir >= 'hF0) && r_eq_0);
            if (take) begin
                m_pc = (m_ir % 16) * 16;
                m_ir = FLUSH ? 'hC8 : fetched;
                m_bt = 1;
            end else begin
                m_pc = (m_pc + 1) % 256;
                m_ir = fetched;
                m_bt = 0;
            end
        end
        #1;
        check_model();
    endtask

    // Called #1 after a posedge: assert, check immediate effect, hold, release.
    task automatic apply_reset(input int hold_cycles);
        reset_n = 1'b0;
        #1;
        m_pc = 0; m_ir = 'hC8; m_bt = 0; m_sr_left = 2;
        check("rst_pc", int'(pc), 0);
        check("rst_ir", int'(ir), 'hC8);
        check("rst_sync_reset", int'(sync_reset), 1);
        check("rst_branch_tkn", int'(branch_tkn), 0);
        repeat (hold_cycles) step();
        reset_n = 1'b1;
    endtask

    task automatic fill_rom(input logic [7:0] val);
        for (int i = 0; i < 256; i++) rom[i] = val;
    endtask

    typedef struct {
        int addr;
        int op;
        bit r;
        int exp_pc;
        bit exp_bt;
    } vec_t;

    vec_t vecs [$];

    initial begin
        int exp_ir;
        reset_n = 1'b1;
        r_eq_0  = 1'b0;
        fill_rom(8'hC8);
        m_pc = 0; m_ir = 'hC8; m_bt = 0; m_sr_left = 2;
        @(posedge clk); #1;
        apply_reset(2);

        // T1: reset mid-run and release timing
        repeat (12) step();
        check("t1_pc_before", int'(pc), 10);
        apply_reset(3);
        step();
        check("t1_sr_1clk", int'(sync_reset), 1);
        step();
        check("t1_sr_2clk", int'(sync_reset), 0);
        check("t1_pc_held", int'(pc), 0);
        step();
        check("t1_pc_first_inc", int'(pc), 1);

        // T2: straight line with wrap
        fill_rom(8'hC8);
        apply_reset(1);
        repeat (257) step();
        check("t2_pc_ff", int'(pc), 'hFF);
        step();
        check("t2_pc_wrap", int'(pc), 0);
        check("t2_bt", int'(branch_tkn), 0);
        step();
        check("t2_pc_after_wrap", int'(pc), 1);

        // T3/T4 and extra branch vectors
        vecs.push_back('{'h05, 'hE3, 1'b0, 'h30, 1'b1});
        vecs.push_back('{'h05, 'hE3, 1'b1, 'h30, 1'b1});
        vecs.push_back('{'h10, 'hF2, 1'b0, 'h20, 1'b1});
        vecs.push_back('{'h10, 'hF2, 1'b1, 'h12, 1'b0});
        vecs.push_back('{'h07, 'hF0, 1'b0, 'h00, 1'b1});
        vecs.push_back('{'h20, 'hE0, 1'b1, 'h00, 1'b1});
        vecs.push_back('{'h40, 'hDF, 1'b0, 'h42, 1'b0});
        vecs.push_back('{'hFE, 'hEF, 1'b0, 'hF0, 1'b1});
        vecs.push_back('{'h33, 'hFA, 1'b1, 'h35, 1'b0});
        foreach (vecs[k]) begin
            fill_rom(8'hC8);
            rom[vecs[k].addr] = 8'(vecs[k].op);
            rom[(vecs[k].addr + 1) % 256] = 8'h5A;
            r_eq_0 = vecs[k].r;
            apply_reset(1);
            repeat (vecs[k].addr + 3) step();
            check("vec_ir_exec", int'(ir), vecs[k].op);
            step();
            exp_ir = (FLUSH && vecs[k].exp_bt) ? 'hC8 : 'h5A;
            check("vec_pc", int'(pc), vecs[k].exp_pc);
            check("vec_bt", int'(branch_tkn), int'(vecs[k].exp_bt));
            check("vec_ir", int'(ir), exp_ir);
        end
        r_eq_0 = 1'b0;

        // T5: branch in the delay slot
        fill_rom(8'hC8);
        rom[5] = 8'hE3;
        rom[6] = 8'hE4;
        apply_reset(1);
        repeat (8) step();
        check("t5_ir_e3", int'(ir), 'hE3);
        step();
        check("t5_pc_30", int'(pc), 'h30);
        check("t5_ir_slot", int'(ir), FLUSH ? 'hC8 : 'hE4);
        step();
        check("t5_pc_next", int'(pc), FLUSH ? 'h31 : 'h40);

        // T6: reset asserted in the cycle ir=E3
        fill_rom(8'hC8);
        rom[5] = 8'hE3;
        apply_reset(1);
        repeat (8) step();
        check("t6_ir_e3", int'(ir), 'hE3);
        apply_reset(3);
        check("t6_pc_not_30", int'(pc), 0);
        check("t6_bt", int'(branch_tkn), 0);
        repeat (3) step();
        check("t6_pc_resume", int'(pc), 1);

        // Randomized program and zero flag
        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom_range(0, 255));
        apply_reset(1);
        for (int n = 0; n < 3000; n++) begin
            r_eq_0 = 1'($urandom_range(0, 1));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
